// File: rtl/lock_ctrl_pkg.sv
// Shared types and helpers for the lock status controller: FSM state encoding,
// counter width helper and the default debug key.
package lock_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_UNLOCKED  = 3'd0,
    ST_LOCKED    = 3'd1,
    ST_DBG_CHECK = 3'd2,
    ST_DBG_OPEN  = 3'd3,
    ST_LOCKOUT   = 3'd4
  } state_t;

  localparam logic [15:0] DEFAULT_DBG_KEY = 16'hA5C3;

  // Bits needed to hold 0..max_val; never less than one bit.
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/lock_down_counter.sv
// Loadable down-counter that holds at zero instead of wrapping; zero flags the
// final cycle of a timed interval.
module lock_down_counter #(
  parameter int               WIDTH    = 8,
  parameter logic [WIDTH-1:0] LOAD_VAL = '0
) (
  input  logic clk,
  input  logic resetn,
  input  logic load,
  input  logic en,
  output logic zero
);

  logic [WIDTH-1:0] cnt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= LOAD_VAL;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - WIDTH'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/lock_status_controller.sv
// Sticky lock bit plus key-checked, time-limited debug unlock with lockout after
// repeated key mismatches. Define LOCK_AUDIT_EN to add the blocked-write counter.
module lock_status_controller
  import lock_ctrl_pkg::*;
#(
  parameter int               KEY_W          = 16,
  parameter logic [KEY_W-1:0] DBG_KEY        = KEY_W'(DEFAULT_DBG_KEY),
  parameter int               MAX_FAIL       = 3,
  parameter int               LOCKOUT_CYCLES = 256,
  parameter int               SESSION_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             lock_req,
  input  logic             dbg_req,
  input  logic [KEY_W-1:0] dbg_key,
  input  logic             dbg_exit,
  output logic             lock_status,
  output logic             debug_unlocked,
  output logic             dbg_fail,
  output logic             lockout_active
`ifdef LOCK_AUDIT_EN
  ,
  input  logic             write,
  output logic [7:0]       blocked_cnt
`endif
);

  localparam int SESS_W = cnt_w(SESSION_CYCLES - 1);
  localparam int LOCK_W = cnt_w(LOCKOUT_CYCLES - 1);
  localparam int FAIL_W = cnt_w(MAX_FAIL);

  state_t            state;
  logic [KEY_W-1:0]  key_q;
  logic [FAIL_W-1:0] fail_cnt;
  logic [FAIL_W-1:0] fail_nxt;
  logic              key_match;
  logic              sess_load;
  logic              sess_zero;
  logic              lk_load;
  logic              lk_zero;

  assign key_match = (key_q == DBG_KEY);
  assign fail_nxt  = fail_cnt + FAIL_W'(1);
  assign sess_load = (state == ST_DBG_CHECK) && key_match;
  assign lk_load   = (state == ST_DBG_CHECK) && !key_match && (fail_nxt == FAIL_W'(MAX_FAIL));

  lock_down_counter #(
    .WIDTH    (SESS_W),
    .LOAD_VAL (SESS_W'(SESSION_CYCLES - 1))
  ) u_session_cnt (
    .clk    (clk),
    .resetn (resetn),
    .load   (sess_load),
    .en     (state == ST_DBG_OPEN),
    .zero   (sess_zero)
  );

  lock_down_counter #(
    .WIDTH    (LOCK_W),
    .LOAD_VAL (LOCK_W'(LOCKOUT_CYCLES - 1))
  ) u_lockout_cnt (
    .clk    (clk),
    .resetn (resetn),
    .load   (lk_load),
    .en     (state == ST_LOCKOUT),
    .zero   (lk_zero)
  );

  // Candidate key is plain data; it is only consulted in the cycle after capture.
  always_ff @(posedge clk) begin
    if ((state == ST_LOCKED) && dbg_req) begin
      key_q <= dbg_key;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state          <= ST_UNLOCKED;
      fail_cnt       <= '0;
      lock_status    <= 1'b0;
      debug_unlocked <= 1'b0;
      dbg_fail       <= 1'b0;
      lockout_active <= 1'b0;
    end else begin
      dbg_fail <= 1'b0;
      case (state)
        ST_UNLOCKED: begin
          if (lock_req) begin
            state       <= ST_LOCKED;
            lock_status <= 1'b1;
          end
        end
        ST_LOCKED: begin
          if (dbg_req) begin
            state <= ST_DBG_CHECK;
          end
        end
        ST_DBG_CHECK: begin
          if (key_match) begin
            state          <= ST_DBG_OPEN;
            debug_unlocked <= 1'b1;
            fail_cnt       <= '0;
          end else begin
            dbg_fail <= 1'b1;
            fail_cnt <= fail_nxt;
            if (fail_nxt == FAIL_W'(MAX_FAIL)) begin
              state          <= ST_LOCKOUT;
              lockout_active <= 1'b1;
            end else begin
              state <= ST_LOCKED;
            end
          end
        end
        ST_DBG_OPEN: begin
          if (dbg_exit || sess_zero) begin
            state          <= ST_LOCKED;
            debug_unlocked <= 1'b0;
          end
        end
        ST_LOCKOUT: begin
          if (lk_zero) begin
            state          <= ST_LOCKED;
            lockout_active <= 1'b0;
            fail_cnt       <= '0;
          end
        end
        default: state <= ST_UNLOCKED;
      endcase
    end
  end

`ifdef LOCK_AUDIT_EN
  // Counts writes that the locked register rejects; saturates rather than wraps.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      blocked_cnt <= 8'd0;
    end else if (write && lock_status && !debug_unlocked && (blocked_cnt != 8'hFF)) begin
      blocked_cnt <= blocked_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_lock_status_controller.sv
// Scoreboard bench for lock_status_controller: stimulus queues expected output
// changes with the cycle they must appear in; a monitor pops them on every change.
module tb_lock_status_controller;

  localparam int             KEY_W = 16;
  localparam logic [15:0]    GOOD  = 16'hA5C3;
  localparam int             SESS  = 8;
  localparam int             LOCKC = 16;

  typedef struct packed {
    int         cyc;
    logic [3:0] vec;
  } exp_t;

  logic             clk;
  logic             resetn;
  logic             lock_req;
  logic             dbg_req;
  logic [KEY_W-1:0] dbg_key;
  logic             dbg_exit;
  logic             lock_status;
  logic             debug_unlocked;
  logic             dbg_fail;
  logic             lockout_active;
`ifdef LOCK_AUDIT_EN
  logic             write;
  logic [7:0]       blocked_cnt;
`endif

  logic [3:0] outs;
  logic [3:0] prev_outs;
  logic [3:0] last_exp;
  exp_t       exp_q[$];
  int         cyc;
  int         checks;
  int         failures;

  lock_status_controller #(
    .KEY_W          (KEY_W),
    .DBG_KEY        (GOOD),
    .MAX_FAIL       (3),
    .LOCKOUT_CYCLES (LOCKC),
    .SESSION_CYCLES (SESS)
  ) dut (
    .clk            (clk),
    .resetn         (resetn),
    .lock_req       (lock_req),
    .dbg_req        (dbg_req),
    .dbg_key        (dbg_key),
    .dbg_exit       (dbg_exit),
    .lock_status    (lock_status),
    .debug_unlocked (debug_unlocked),
    .dbg_fail       (dbg_fail),
    .lockout_active (lockout_active)
`ifdef LOCK_AUDIT_EN
    ,
    .write          (write),
    .blocked_cnt    (blocked_cnt)
`endif
  );

  assign outs = {lock_status, debug_unlocked, dbg_fail, lockout_active};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_chg(input int dly, input logic [3:0] v);
    exp_t e;
    e.cyc = cyc + dly;
    e.vec = v;
    exp_q.push_back(e);
    last_exp = v;
  endtask

  // Reset asserted between edges must clear the outputs without waiting for a clock.
  task automatic async_reset(input string name);
    #2;
    resetn = 1'b0;
    if (last_exp != 4'b0000) expect_chg(0, 4'b0000);
    #1;
    check(name, outs, 4'b0000);
    tick();
    resetn = 1'b1;
    tick();
  endtask

  // Monitor: every output change must be the next queued one, in the queued cycle.
  always @(negedge clk) begin
    exp_t e;
    if (outs !== prev_outs) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_change actual=%b required=%b (cycle %0d)", outs, prev_outs, cyc);
      end else begin
        e = exp_q.pop_front();
        check("out_vec", outs, e.vec);
        check("out_cycle", cyc, e.cyc);
      end
      check("inv_unlock_needs_lock", outs[2] & ~outs[3], 1'b0);
      check("inv_lockout_vs_unlock", outs[2] & outs[0], 1'b0);
      prev_outs = outs;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    checks    = 0;
    failures  = 0;
    prev_outs = 4'b0000;
    last_exp  = 4'b0000;
    resetn    = 1'b0;
    lock_req  = 1'b0;
    dbg_req   = 1'b0;
    dbg_key   = '0;
    dbg_exit  = 1'b0;
`ifdef LOCK_AUDIT_EN
    write     = 1'b0;
`endif
    repeat (3) tick();
    check("reset_outputs", outs, 4'b0000);
    resetn = 1'b1;
    tick();

    // Sticky lock: second lock_req and dbg_exit change nothing.
    lock_req = 1'b1; expect_chg(1, 4'b1000); tick(); lock_req = 1'b0;
    tick();
    lock_req = 1'b1; dbg_exit = 1'b1; tick(); lock_req = 1'b0; dbg_exit = 1'b0;
    repeat (2) tick();
    check("sticky_lock", lock_status, 1'b1);
    async_reset("async_reset_locked");

    // Good key opens two edges later; dbg_exit after 5 open cycles closes it.
    lock_req = 1'b1; expect_chg(1, 4'b1000); tick(); lock_req = 1'b0;
    dbg_req = 1'b1; dbg_key = GOOD; expect_chg(2, 4'b1100); tick(); dbg_req = 1'b0; dbg_key = '0;
    repeat (5) tick();
    dbg_exit = 1'b1; expect_chg(1, 4'b1000); tick(); dbg_exit = 1'b0;
    tick();

    // Session budget expiry: exactly SESS cycles open.
    dbg_req = 1'b1; dbg_key = GOOD; expect_chg(2, 4'b1100); expect_chg(2 + SESS, 4'b1000);
    tick(); dbg_req = 1'b0; dbg_key = '0;
    repeat (SESS + 3) tick();

    // dbg_exit on the final session cycle gives one transition only.
    dbg_req = 1'b1; dbg_key = GOOD; expect_chg(2, 4'b1100); expect_chg(2 + SESS, 4'b1000);
    tick(); dbg_req = 1'b0; dbg_key = '0;
    repeat (SESS) tick();
    dbg_exit = 1'b1; tick(); dbg_exit = 1'b0;
    repeat (3) tick();

    // Two mismatches each pulse dbg_fail and return to LOCKED.
    for (int i = 0; i < 2; i++) begin
      dbg_req = 1'b1; dbg_key = 16'h0000;
      expect_chg(2, 4'b1010); expect_chg(3, 4'b1000);
      tick(); dbg_req = 1'b0;
      repeat (2) tick();
    end
    // Third mismatch enters LOCKOUT; a good key and dbg_exit inside it are ignored.
    dbg_req = 1'b1; dbg_key = 16'h0000;
    expect_chg(2, 4'b1011); expect_chg(3, 4'b1001); expect_chg(2 + LOCKC, 4'b1000);
    tick(); dbg_req = 1'b0;
    tick();
    dbg_req = 1'b1; dbg_key = GOOD; dbg_exit = 1'b1; tick();
    dbg_req = 1'b0; dbg_key = '0; dbg_exit = 1'b0;
    repeat (LOCKC + 2) tick();
    check("lockout_released", lockout_active, 1'b0);
    // fail_cnt was cleared: a single new mismatch must not re-enter LOCKOUT.
    dbg_req = 1'b1; dbg_key = 16'h1234;
    expect_chg(2, 4'b1010); expect_chg(3, 4'b1000);
    tick(); dbg_req = 1'b0;
    repeat (3) tick();

    // Simultaneous lock_req and dbg_req from UNLOCKED: lock only.
    async_reset("async_reset_after_lockout");
    lock_req = 1'b1; dbg_req = 1'b1; dbg_key = GOOD; expect_chg(1, 4'b1000);
    tick(); lock_req = 1'b0; dbg_req = 1'b0; dbg_key = '0;
    repeat (4) tick();
    check("lock_wins_no_debug", debug_unlocked, 1'b0);

`ifdef LOCK_AUDIT_EN
    async_reset("async_reset_audit");
    repeat (3) begin write = 1'b1; tick(); write = 1'b0; tick(); end
    check("audit_unlocked_no_count", blocked_cnt, 8'd0);
    lock_req = 1'b1; expect_chg(1, 4'b1000); tick(); lock_req = 1'b0;
    dbg_req = 1'b1; dbg_key = GOOD; expect_chg(2, 4'b1100); expect_chg(2 + SESS, 4'b1000);
    tick(); dbg_req = 1'b0; dbg_key = '0;
    tick();
    write = 1'b1; repeat (4) tick(); write = 1'b0;
    check("audit_session_no_count", blocked_cnt, 8'd0);
    repeat (SESS) tick();
    repeat (300) begin write = 1'b1; tick(); write = 1'b0; tick(); end
    check("audit_saturate", blocked_cnt, 8'd255);
`endif

    repeat (2) tick();
    check("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
